// File: rtl/ccl_pass_scheduler_if.sv
// rtl/ccl_pass_scheduler_if.sv - handshake bundle between frame controller, camera stream and pass scheduler
interface ccl_pass_scheduler_if #(
  parameter int ADDR_W = 16
);
  // Frame controller / camera side
  logic              new_frame_in;
  logic [10:0]       x_in;
  logic [9:0]        y_in;
  logic              valid_in;
  logic              stall_in;

  // Capture write port
  logic              cap_we_out;
  logic [ADDR_W-1:0] cap_addr_out;

  // Scan read port
  logic [ADDR_W-1:0] rd_addr_out;
  logic              rd_en_out;

  // Tags aligned with BRAM read data
  logic              pix_valid_out;
  logic [10:0]       pix_x_out;
  logic [9:0]        pix_y_out;
  logic              pix_first_col_out;
  logic              pix_last_col_out;
  logic              pix_first_row_out;

  // Status
  logic [1:0]        pass_out;
  logic              busy_out;
  logic              done_out;
  logic              dropped_frame_out;

  modport master (
    output new_frame_in, x_in, y_in, valid_in, stall_in,
    input  cap_we_out, cap_addr_out, rd_addr_out, rd_en_out,
    input  pix_valid_out, pix_x_out, pix_y_out,
    input  pix_first_col_out, pix_last_col_out, pix_first_row_out,
    input  pass_out, busy_out, done_out, dropped_frame_out
  );

  modport slave (
    input  new_frame_in, x_in, y_in, valid_in, stall_in,
    output cap_we_out, cap_addr_out, rd_addr_out, rd_en_out,
    output pix_valid_out, pix_x_out, pix_y_out,
    output pix_first_col_out, pix_last_col_out, pix_first_row_out,
    output pass_out, busy_out, done_out, dropped_frame_out
  );
endinterface

// File: rtl/ccl_pass_scheduler.sv
// rtl/ccl_pass_scheduler.sv - capture / first pass / second pass sequencer with latency-matched pixel tags
module ccl_pass_scheduler #(
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 180,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = $clog2(WIDTH * HEIGHT)
) (
  input logic               clk_in,
  input logic               rst_in,
  ccl_pass_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    PASS1,
    DRAIN1,
    PASS2,
    DRAIN2,
    DONE
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic        first_col;
    logic        last_col;
    logic        first_row;
  } tag_t;

  localparam logic [10:0]       WIDTH_X  = 11'(WIDTH);
  localparam logic [10:0]       X_LAST   = 11'(WIDTH - 1);
  localparam logic [9:0]        HEIGHT_Y = 10'(HEIGHT);
  localparam logic [9:0]        Y_LAST   = 10'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);
  localparam int                DCW      = $clog2(READ_LATENCY + 1);
  localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(READ_LATENCY - 1);

  state_t          state;
  logic [10:0]     scan_x;
  logic [9:0]      scan_y;
  logic [DCW-1:0]  drain_cnt;
  logic [1:0]      pass_q;
  logic            busy_q;
  logic            done_q;
  logic            drop_q;
  tag_t            tag_pipe [READ_LATENCY];

  logic            scanning;
  logic            in_range;
  logic            cap_we;
  logic            rd_en;
  logic            last_issue;
  logic            last_pixel;
  tag_t            issue_tag;

  // Issue-side decode: capture write enable, read issue and the tag launched with each read
  always_comb begin
    scanning   = (state == PASS1) || (state == PASS2);
    in_range   = (bus.x_in < WIDTH_X) && (bus.y_in < HEIGHT_Y);
    cap_we     = (state == CAPTURE) && bus.valid_in && in_range;
    last_pixel = cap_we && (bus.x_in == X_LAST) && (bus.y_in == Y_LAST);
    rd_en      = scanning && !bus.stall_in;
    last_issue = (scan_x == X_LAST) && (scan_y == Y_LAST);
    issue_tag  = '0;
    if (rd_en) begin
      issue_tag.valid     = 1'b1;
      issue_tag.x         = scan_x;
      issue_tag.y         = scan_y;
      issue_tag.first_col = (scan_x == 11'd0);
      issue_tag.last_col  = (scan_x == X_LAST);
      issue_tag.first_row = (scan_y == 10'd0);
    end
  end

  // Addresses are held at zero outside the state that owns them so reset forces every output low
  assign bus.cap_we_out   = cap_we;
  assign bus.cap_addr_out = (state == CAPTURE)
                            ? (ADDR_W'(bus.x_in) + ADDR_W'(bus.y_in) * WIDTH_A)
                            : '0;
  assign bus.rd_en_out    = rd_en;
  assign bus.rd_addr_out  = scanning
                            ? (ADDR_W'(scan_x) + ADDR_W'(scan_y) * WIDTH_A)
                            : '0;

  assign bus.pix_valid_out     = tag_pipe[READ_LATENCY-1].valid;
  assign bus.pix_x_out         = tag_pipe[READ_LATENCY-1].x;
  assign bus.pix_y_out         = tag_pipe[READ_LATENCY-1].y;
  assign bus.pix_first_col_out = tag_pipe[READ_LATENCY-1].first_col;
  assign bus.pix_last_col_out  = tag_pipe[READ_LATENCY-1].last_col;
  assign bus.pix_first_row_out = tag_pipe[READ_LATENCY-1].first_row;

  assign bus.pass_out          = pass_q;
  assign bus.busy_out          = busy_q;
  assign bus.done_out          = done_q;
  assign bus.dropped_frame_out = drop_q;

  // Frame sequencer: state, raster scan counters, drain timer and registered status outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      scan_x    <= '0;
      scan_y    <= '0;
      drain_cnt <= '0;
      pass_q    <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Any request outside IDLE is refused, including the DONE cycle itself
      drop_q <= bus.new_frame_in && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.new_frame_in) begin
            state  <= CAPTURE;
            busy_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (last_pixel) begin
            state  <= PASS1;
            pass_q <= 2'd1;
            scan_x <= '0;
            scan_y <= '0;
          end
        end
        PASS1, PASS2: begin
          if (rd_en) begin
            if (last_issue) begin
              state     <= (state == PASS1) ? DRAIN1 : DRAIN2;
              drain_cnt <= '0;
            end else if (scan_x == X_LAST) begin
              scan_x <= '0;
              scan_y <= scan_y + 10'd1;
            end else begin
              scan_x <= scan_x + 11'd1;
            end
          end
        end
        DRAIN1: begin
          // The last read leaves the tag pipeline on the final drain cycle
          if (drain_cnt == DRAIN_LAST) begin
            state  <= PASS2;
            pass_q <= 2'd2;
            scan_x <= '0;
            scan_y <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DRAIN2: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= DONE;
            pass_q <= 2'd0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          pass_q <= 2'd0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag delay line matching BRAM read latency; never stalls so issued reads always emerge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ccl_pass_scheduler.sv
// tb/tb_ccl_pass_scheduler.sv - self-checking bench for ccl_pass_scheduler
module tb_ccl_pass_scheduler;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int RL = 2;
  localparam int AW = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  ccl_pass_scheduler_if #(.ADDR_W(AW)) bus ();

  ccl_pass_scheduler #(
    .WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL), .ADDR_W(AW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  typedef struct {
    logic        valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic        exp_we;
    int          exp_addr;
  } cap_vec_t;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        fc;
    logic        lc;
    logic        fr;
    int          t;
  } exp_tag_t;

  cap_vec_t cap_tab[$];
  exp_tag_t sb[$];
  exp_tag_t mon_e;
  int       exp_idx = 0;
  bit       mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {24'b0, bus.cap_we_out, bus.cap_addr_out, bus.rd_addr_out, bus.rd_en_out,
            bus.pix_valid_out, bus.pix_x_out, bus.pix_y_out, bus.pix_first_col_out,
            bus.pix_last_col_out, bus.pix_first_row_out, bus.pass_out, bus.busy_out,
            bus.done_out, bus.dropped_frame_out};
  endfunction

  function automatic void add_vec(input logic v, input int x, input int y, input logic we, input int a);
    cap_vec_t c;
    c.valid = v; c.x = 11'(x); c.y = 10'(y); c.exp_we = we; c.exp_addr = a;
    cap_tab.push_back(c);
  endfunction

  // Scoreboard: each issued read pushes its expected tag; each aligned tag pops and compares
  always @(negedge clk_in) begin
    if (mon_en && !rst_in) begin
      if (bus.pix_valid_out) begin
        check("pix_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("pix_tag",
                {40'b0, bus.pix_x_out, bus.pix_y_out, bus.pix_first_col_out,
                 bus.pix_last_col_out, bus.pix_first_row_out},
                {40'b0, mon_e.x, mon_e.y, mon_e.fc, mon_e.lc, mon_e.fr});
          check("pix_latency", 64'(cyc - mon_e.t), 64'(RL));
        end
      end
      if (bus.rd_en_out) begin
        check("rd_addr", 64'(bus.rd_addr_out), 64'(exp_idx));
        mon_e.x  = 11'(exp_idx % W);
        mon_e.y  = 10'(exp_idx / W);
        mon_e.fc = ((exp_idx % W) == 0);
        mon_e.lc = ((exp_idx % W) == W - 1);
        mon_e.fr = ((exp_idx / W) == 0);
        mon_e.t  = cyc;
        sb.push_back(mon_e);
        exp_idx = (exp_idx + 1) % (W * H);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    bus.new_frame_in = 1'b0;
    bus.valid_in     = 1'b0;
    bus.stall_in     = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic start_frame();
    tick();
    bus.new_frame_in = 1'b1;
    sample();
    check("busy_before_start", 64'(bus.busy_out), 64'd0);
    tick();
    sample();
    check("busy_after_start", 64'(bus.busy_out), 64'd1);
  endtask

  task automatic run_capture(output int cap_end);
    foreach (cap_tab[i]) begin
      tick();
      bus.valid_in = cap_tab[i].valid;
      bus.x_in     = cap_tab[i].x;
      bus.y_in     = cap_tab[i].y;
      sample();
      check("cap_we", 64'(bus.cap_we_out), 64'(cap_tab[i].exp_we));
      if (cap_tab[i].exp_we) check("cap_addr", 64'(bus.cap_addr_out), 64'(cap_tab[i].exp_addr));
      check("in_capture", {61'b0, bus.busy_out, bus.pass_out}, 64'b100);
    end
    cap_end = cyc;
  endtask

  task automatic wait_done(input int budget, input bit drop_on_done, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done_out) begin
        at = cyc;
        if (drop_on_done) bus.new_frame_in = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(at >= 0), 64'd1);
    sample();
    check("done_cycle", {61'b0, bus.done_out, bus.busy_out, bus.pass_out == 2'd0}, 64'b111);
    tick();
    sample();
    check("after_done", {61'b0, bus.done_out, bus.busy_out, bus.dropped_frame_out},
          {61'b0, 1'b0, 1'b0, drop_on_done});
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("issue_count", 64'(exp_idx), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ce;
    int at;
    int bad;

    // Capture vectors: raster pixels with out-of-range and invalid pixels interleaved
    for (int p = 0; p < W * H; p++) begin
      if (p == 2)  add_vec(1'b1, 5, 0, 1'b0, 0);
      if (p == 7)  add_vec(1'b1, 3, 3, 1'b0, 0);
      if (p == 11) begin
        add_vec(1'b1, 5, 2, 1'b0, 0);
        add_vec(1'b0, 3, 2, 1'b0, 0);
      end
      add_vec(1'b1, p % W, p / W, 1'b1, p);
    end

    rst_in = 1'b0;
    bus.new_frame_in = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.valid_in = 1'b0;
    bus.stall_in = 1'b0;
    #1 rst_in = 1'b1;
    #1 check("reset_outputs", outs(), 64'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    mon_en = 1'b1;

    // Frame 1: plain run, total length from capture end to done
    start_frame();
    run_capture(ce);
    wait_done(200, 1'b0, at);
    check("frame_len", 64'(at - ce), 64'(W*H + RL + W*H + RL + 1));

    // Frame 2: three stall cycles at scan (1,1)
    start_frame();
    run_capture(ce);
    for (int k = 1; k <= 9; k++) begin
      tick();
      bus.stall_in = (k >= 6 && k <= 8);
      sample();
      if (k == 1) check("pass1_start", {62'b0, bus.pass_out}, 64'd1);
      if (k >= 6 && k <= 8) begin
        check("stall_rd_en", 64'(bus.rd_en_out), 64'd0);
        check("stall_rd_addr", 64'(bus.rd_addr_out), 64'd5);
        check("stall_inflight", 64'(bus.pix_valid_out), 64'(k <= 7));
      end
    end
    wait_done(200, 1'b0, at);
    check("stall_frame_len", 64'(at - ce), 64'(W*H + RL + W*H + RL + 1 + 3));

    // Frame 3: new_frame during PASS1 and on the done cycle are both dropped
    start_frame();
    run_capture(ce);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.new_frame_in = (k == 3);
      sample();
      if (k == 3) check("drop_not_yet", 64'(bus.dropped_frame_out), 64'd0);
      if (k == 4) check("drop_pass1", {61'b0, bus.dropped_frame_out, bus.pass_out}, 64'b101);
      if (k == 5) check("drop_one_cycle", 64'(bus.dropped_frame_out), 64'd0);
    end
    wait_done(200, 1'b1, at);
    tick();
    sample();
    check("idle_after_drop", {62'b0, bus.busy_out, bus.dropped_frame_out}, 64'd0);

    // Frame 4: accepted after drops, then async reset in the middle of PASS2
    start_frame();
    run_capture(ce);
    for (int k = 1; k <= 20; k++) begin
      tick();
      sample();
    end
    check("in_pass2", {62'b0, bus.pass_out}, 64'd2);
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1 check("async_reset_outputs", outs(), 64'd0);
    check("async_reset_pass", {62'b0, bus.pass_out}, 64'd0);
    sb.delete();
    exp_idx = 0;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      sample();
      if (bus.pix_valid_out || bus.rd_en_out || bus.busy_out) bad++;
    end
    check("quiet_after_reset", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
